// File: rtl/interface_rd.sv
// interface_rd: read side of the bank interface.
// Reads all 8 banks, undoes the write-side lane rotation and routes the word either to
// the HRMF datapath (registered single-cycle pulse) or to a credit-protected FWFT buffer.
module interface_rd #(
    parameter int unsigned DW         = 64,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          RD_EN,
    output logic          RD_RDY,
    input  logic          SEL_EXTN,
    input  logic [2:0]    SEL_PERMR,
    input  logic [DW-1:0] D0_MEM,
    input  logic [DW-1:0] D1_MEM,
    input  logic [DW-1:0] D2_MEM,
    input  logic [DW-1:0] D3_MEM,
    input  logic [DW-1:0] D4_MEM,
    input  logic [DW-1:0] D5_MEM,
    input  logic [DW-1:0] D6_MEM,
    input  logic [DW-1:0] D7_MEM,
    output logic [DW-1:0] Q0_HRMF,
    output logic [DW-1:0] Q1_HRMF,
    output logic [DW-1:0] Q2_HRMF,
    output logic [DW-1:0] Q3_HRMF,
    output logic [DW-1:0] Q4_HRMF,
    output logic [DW-1:0] Q5_HRMF,
    output logic [DW-1:0] Q6_HRMF,
    output logic [DW-1:0] Q7_HRMF,
    output logic          VALID_HRMF,
    output logic [DW-1:0] Q0_EXTN,
    output logic [DW-1:0] Q1_EXTN,
    output logic [DW-1:0] Q2_EXTN,
    output logic [DW-1:0] Q3_EXTN,
    output logic [DW-1:0] Q4_EXTN,
    output logic [DW-1:0] Q5_EXTN,
    output logic [DW-1:0] Q6_EXTN,
    output logic [DW-1:0] Q7_EXTN,
    output logic          VALID_EXTN,
    input  logic          READY_EXTN
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned WW = 8 * DW;

    typedef struct packed {
        logic       acc;
        logic       hrmf;
        logic [2:0] s;
    } tag_t;

    logic            acc;
    logic            credit_inc;
    logic            pop;
    logic            fifo_wr;
    logic [CW-1:0]   cnt;
    tag_t            dly [RD_LAT];
    tag_t            al;
    logic [DW-1:0]   d_mem [8];
    logic [DW-1:0]   derot [8];
    logic [WW-1:0]   derot_w;
    logic [DW-1:0]   q_hrmf [8];
    logic            valid_hrmf;
    logic [WW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;
    logic [WW-1:0]   head;

    assign d_mem[0] = D0_MEM;
    assign d_mem[1] = D1_MEM;
    assign d_mem[2] = D2_MEM;
    assign d_mem[3] = D3_MEM;
    assign d_mem[4] = D4_MEM;
    assign d_mem[5] = D5_MEM;
    assign d_mem[6] = D6_MEM;
    assign d_mem[7] = D7_MEM;

    // Credit covers in-flight EXTN reads plus buffered words, so the buffer cannot overflow.
    assign RD_RDY     = RSTN & (cnt < CW'(FIFO_DEPTH));
    assign acc        = RD_EN & RD_RDY;
    assign credit_inc = acc & ~SEL_EXTN;
    assign al         = dly[RD_LAT-1];
    assign fifo_wr    = al.acc & ~al.hrmf;
    assign VALID_EXTN = (occ != '0);
    assign pop        = VALID_EXTN & READY_EXTN;
    assign head       = fifo_mem[rd_ptr];

    // Tag delay line: request tags emerge in the cycle their bank data is valid.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int unsigned i = 0; i < RD_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0].acc  <= acc;
            dly[0].hrmf <= SEL_EXTN;
            dly[0].s    <= SEL_PERMR;
            for (int unsigned i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    // De-rotation: lane i takes bank (i + s) mod 8; the 3-bit cast performs the wrap.
    always_comb begin
        derot_w = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            derot[i] = d_mem[3'(i + 32'(al.s))];
            derot_w[i*DW +: DW] = derot[i];
        end
    end

    // HRMF output register: loads only on an aligned HRMF read, otherwise holds.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid_hrmf <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) q_hrmf[i] <= '0;
        end else begin
            valid_hrmf <= al.acc & al.hrmf;
            if (al.acc && al.hrmf) begin
                for (int unsigned i = 0; i < 8; i++) q_hrmf[i] <= derot[i];
            end
        end
    end

    // External buffer: first-word-fall-through, pointers wrap at FIFO_DEPTH.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= derot_w;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(rd_ptr + 1'b1);
            end
            case ({fifo_wr, pop})
                2'b10:   occ <= CW'(occ + 1'b1);
                2'b01:   occ <= CW'(occ - 1'b1);
                default: occ <= occ;
            endcase
        end
    end

    // Credit counter: +1 per accepted EXTN read, -1 per pop.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= '0;
        end else begin
            case ({credit_inc, pop})
                2'b10:   cnt <= CW'(cnt + 1'b1);
                2'b01:   cnt <= CW'(cnt - 1'b1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign VALID_HRMF = valid_hrmf;
    assign Q0_HRMF = q_hrmf[0];
    assign Q1_HRMF = q_hrmf[1];
    assign Q2_HRMF = q_hrmf[2];
    assign Q3_HRMF = q_hrmf[3];
    assign Q4_HRMF = q_hrmf[4];
    assign Q5_HRMF = q_hrmf[5];
    assign Q6_HRMF = q_hrmf[6];
    assign Q7_HRMF = q_hrmf[7];

    assign Q0_EXTN = head[0*DW +: DW];
    assign Q1_EXTN = head[1*DW +: DW];
    assign Q2_EXTN = head[2*DW +: DW];
    assign Q3_EXTN = head[3*DW +: DW];
    assign Q4_EXTN = head[4*DW +: DW];
    assign Q5_EXTN = head[5*DW +: DW];
    assign Q6_EXTN = head[6*DW +: DW];
    assign Q7_EXTN = head[7*DW +: DW];

endmodule

// File: tb/tb_interface_rd.sv
// Directed bench for interface_rd. Bank j returns {addr, j} for the address driven
// two cycles earlier, so every expected lane value is {addr, (i + s) mod 8}.
module tb_interface_rd;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        RD_EN;
    logic        RD_RDY;
    logic        SEL_EXTN;
    logic [2:0]  SEL_PERMR;
    logic        READY_EXTN;
    logic        VALID_HRMF;
    logic        VALID_EXTN;
    logic [63:0] dm [8];
    logic [63:0] qh [8];
    logic [63:0] qe [8];
    logic [59:0] addr, a1, a2;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 CLK = ~CLK;

    // Bank model with two-cycle read latency.
    always @(posedge CLK) begin
        a1 <= addr;
        a2 <= a1;
    end

    always_comb begin
        for (int j = 0; j < 8; j++) dm[j] = {a2, 4'(j)};
    end

    interface_rd #(.DW(64), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RSTN(RSTN), .RD_EN(RD_EN), .RD_RDY(RD_RDY),
        .SEL_EXTN(SEL_EXTN), .SEL_PERMR(SEL_PERMR),
        .D0_MEM(dm[0]), .D1_MEM(dm[1]), .D2_MEM(dm[2]), .D3_MEM(dm[3]),
        .D4_MEM(dm[4]), .D5_MEM(dm[5]), .D6_MEM(dm[6]), .D7_MEM(dm[7]),
        .Q0_HRMF(qh[0]), .Q1_HRMF(qh[1]), .Q2_HRMF(qh[2]), .Q3_HRMF(qh[3]),
        .Q4_HRMF(qh[4]), .Q5_HRMF(qh[5]), .Q6_HRMF(qh[6]), .Q7_HRMF(qh[7]),
        .VALID_HRMF(VALID_HRMF),
        .Q0_EXTN(qe[0]), .Q1_EXTN(qe[1]), .Q2_EXTN(qe[2]), .Q3_EXTN(qe[3]),
        .Q4_EXTN(qe[4]), .Q5_EXTN(qe[5]), .Q6_EXTN(qe[6]), .Q7_EXTN(qe[7]),
        .VALID_EXTN(VALID_EXTN), .READY_EXTN(READY_EXTN)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] w(input logic [59:0] a, input int lane, input int s);
        return {a, 4'((lane + s) % 8)};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic rd(input logic hrmf, input logic [2:0] s, input logic [59:0] a);
        RD_EN = 1'b1; SEL_EXTN = hrmf; SEL_PERMR = s; addr = a;
    endtask

    task automatic idle();
        RD_EN = 1'b0;
    endtask

    logic [59:0] expq [$];
    int          n_pop;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RSTN = 1'b0; RD_EN = 1'b0; SEL_EXTN = 1'b0; SEL_PERMR = 3'd0;
        READY_EXTN = 1'b0; addr = '0;
        tick(); tick();
        chk("rst_valid_hrmf", 64'(VALID_HRMF), 64'd0);
        chk("rst_valid_extn", 64'(VALID_EXTN), 64'd0);
        chk("rst_rd_rdy", 64'(RD_RDY), 64'd0);
        chk("rst_qh0", qh[0], 64'd0);
        chk("rst_qe0", qe[0], 64'd0);
        RSTN = 1'b1;
        tick();
        chk("rdy_after_release", 64'(RD_RDY), 64'd1);

        // 1: identity, HRMF, pulse at t+3
        rd(1'b1, 3'd0, 60'h10);
        tick(); idle();
        chk("t1_valid_t1", 64'(VALID_HRMF), 64'd0);
        tick();
        chk("t1_valid_t2", 64'(VALID_HRMF), 64'd0);
        tick();
        chk("t1_valid_t3", 64'(VALID_HRMF), 64'd1);
        for (int i = 0; i < 8; i++) chk("t1_lane", qh[i], 64'h100 + 64'(i));
        tick();
        chk("t1_valid_t4", 64'(VALID_HRMF), 64'd0);
        chk("t1_hold", qh[3], 64'h103);

        // 2: rotation s=3 on EXTN, then sweep s=0..7
        rd(1'b0, 3'd3, 60'h10);
        tick(); idle(); tick(); tick();
        chk("t2_valid", 64'(VALID_EXTN), 64'd1);
        chk("t2_q0", qe[0], 64'h103);
        chk("t2_q4", qe[4], 64'h107);
        chk("t2_q5", qe[5], 64'h100);
        chk("t2_q7", qe[7], 64'h102);
        READY_EXTN = 1'b1;
        tick();
        chk("t2_empty", 64'(VALID_EXTN), 64'd0);
        for (int s = 0; s < 8; s++) begin
            rd(1'b0, 3'(s), 60'h20 + 60'(s));
            tick(); idle(); tick(); tick();
            chk("sweep_valid", 64'(VALID_EXTN), 64'd1);
            for (int i = 0; i < 8; i++) chk("sweep_lane", qe[i], w(60'h20 + 60'(s), i, s));
            tick();
        end

        // 3: backpressure, exactly 4 accepts then drain in order
        READY_EXTN = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("bp_rdy", 64'(RD_RDY), (k < 4) ? 64'd1 : 64'd0);
            rd(1'b0, 3'd2, 60'h30 + 60'((k < 4) ? k : 4));
            tick();
        end
        idle();
        chk("bp_valid", 64'(VALID_EXTN), 64'd1);
        chk("bp_head", qe[0], w(60'h30, 0, 2));
        tick();
        chk("bp_stable", qe[0], w(60'h30, 0, 2));
        chk("bp_rdy_low", 64'(RD_RDY), 64'd0);
        tick();
        chk("bp_stable2", qe[7], w(60'h30, 7, 2));
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", 64'(VALID_EXTN), 64'd1);
            chk("drain_q0", qe[0], w(60'h30 + 60'(j), 0, 2));
            chk("drain_q7", qe[7], w(60'h30 + 60'(j), 7, 2));
            READY_EXTN = 1'b1;
            tick();
        end
        chk("drain_empty", 64'(VALID_EXTN), 64'd0);
        chk("drain_rdy", 64'(RD_RDY), 64'd1);

        // 4: throughput, 16 back-to-back EXTN reads
        for (int k = 0; k < 20; k++) begin
            if (k < 16) begin
                chk("tp_rdy", 64'(RD_RDY), 64'd1);
                rd(1'b0, 3'd5, 60'h40 + 60'(k));
            end else begin
                idle();
            end
            if (k >= 3 && k < 19) begin
                chk("tp_valid", 64'(VALID_EXTN), 64'd1);
                chk("tp_q0", qe[0], w(60'h40 + 60'(k - 3), 0, 5));
            end else begin
                chk("tp_idle", 64'(VALID_EXTN), 64'd0);
            end
            tick();
        end

        // 5: mixed HRMF(s=1)/EXTN(s=6), READY_EXTN toggling
        n_pop = 0;
        for (int k = 0; k < 30; k++) begin
            if (k < 8) begin
                chk("mx_rdy", 64'(RD_RDY), 64'd1);
                if (k % 2 == 0) begin
                    rd(1'b1, 3'd1, 60'h50 + 60'(k));
                end else begin
                    rd(1'b0, 3'd6, 60'h50 + 60'(k));
                    expq.push_back(60'h50 + 60'(k));
                end
            end else begin
                idle();
            end
            if (k >= 3 && k < 13) begin
                if ((k - 3) < 8 && (k - 3) % 2 == 0) begin
                    chk("mx_hvalid", 64'(VALID_HRMF), 64'd1);
                    chk("mx_hq0", qh[0], w(60'h50 + 60'(k - 3), 0, 1));
                    chk("mx_hq7", qh[7], w(60'h50 + 60'(k - 3), 7, 1));
                end else begin
                    chk("mx_hidle", 64'(VALID_HRMF), 64'd0);
                end
            end
            READY_EXTN = (k % 2 == 0);
            if (VALID_EXTN && READY_EXTN) begin
                if (expq.size() == 0) begin
                    chk("mx_extra_word", 64'(VALID_EXTN), 64'd0);
                end else begin
                    chk("mx_eq0", qe[0], w(expq[0], 0, 6));
                    chk("mx_eq2", qe[2], w(expq[0], 2, 6));
                    void'(expq.pop_front());
                    n_pop++;
                end
            end
            tick();
        end
        chk("mx_pops", 64'(n_pop), 64'd4);
        chk("mx_empty", 64'(VALID_EXTN), 64'd0);

        // 6: reset with work buffered and in flight
        READY_EXTN = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd((k >= 2), 3'd4, 60'h60 + 60'(k));
            tick();
        end
        idle();
        chk("mr_pre_hvalid", 64'(VALID_HRMF), 64'd1);
        chk("mr_pre_evalid", 64'(VALID_EXTN), 64'd1);
        RSTN = 1'b0;
        #1;
        chk("mr_hvalid", 64'(VALID_HRMF), 64'd0);
        chk("mr_evalid", 64'(VALID_EXTN), 64'd0);
        chk("mr_rdy", 64'(RD_RDY), 64'd0);
        chk("mr_qh", qh[0], 64'd0);
        chk("mr_qe", qe[0], 64'd0);
        tick();
        RSTN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_hvalid", 64'(VALID_HRMF), 64'd0);
            chk("post_evalid", 64'(VALID_EXTN), 64'd0);
            chk("post_rdy", 64'(RD_RDY), 64'd1);
        end
        // full credit available again after reset
        for (int k = 0; k < 6; k++) begin
            chk("post_credit", 64'(RD_RDY), (k < 4) ? 64'd1 : 64'd0);
            rd(1'b0, 3'd7, 60'h70 + 60'((k < 4) ? k : 4));
            tick();
        end
        idle();
        for (int j = 0; j < 4; j++) begin
            chk("post_valid", 64'(VALID_EXTN), 64'd1);
            chk("post_q1", qe[1], w(60'h70 + 60'(j), 1, 7));
            READY_EXTN = 1'b1;
            tick();
        end
        chk("post_empty", 64'(VALID_EXTN), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
